// File: rtl/rob_commit_unit_pkg.sv
// Shared rv32i types for the ROB retirement stage: ROB head interface, store-buffer entry,
// retirement map and commit FSM state.
package rob_commit_unit_pkg;

  localparam int NUM_ARCH_REG = 32;
  localparam int NUM_PHYS_REG = 64;
  localparam int PHYS_REG_IDX = $clog2(NUM_PHYS_REG) - 1;
  localparam int ARCH_REG_IDX = $clog2(NUM_ARCH_REG) - 1;

  localparam logic [6:0] op_b_store = 7'b0100011;
  localparam logic [6:0] op_b_br    = 7'b1100011;
  localparam logic [6:0] op_b_reg   = 7'b0110011;

  typedef logic [PHYS_REG_IDX:0] pd_t;
  typedef logic [ARCH_REG_IDX:0] rd_t;

  typedef struct packed {
    logic        ready;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    rd_t         rd;
    logic        dest_we;
    pd_t         pd;
    pd_t         pd_old;
    logic [31:0] rd_wdata;
    rd_t         rs1_addr;
    logic [31:0] rs1_rdata;
    rd_t         rs2_addr;
    logic [31:0] rs2_rdata;
    logic        is_branch;
    logic        br_taken;
    logic [31:0] br_target;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  bht_idx;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
  } rob_entry_t;

  typedef struct packed {
    rob_entry_t rob_entry;
    logic       is_rob_empty;
  } ROB_to_RRF_t;

  typedef struct packed {
    logic dequeue;
  } RRF_to_ROB_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } pcsb_entry_t;

  typedef enum logic [1:0] {CS_RUN, CS_FLUSH, CS_HALT} commit_state_t;

  typedef pd_t [NUM_ARCH_REG-1:0] rrat_map_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
    logic       taken;
  } bp_update_t;

endpackage

// File: rtl/rob_commit_unit_rrat.sv
// Retirement RAT: identity map out of reset, one write port, whole map visible every cycle.
module rob_commit_unit_rrat
  import rob_commit_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      we,
  input  rd_t       rd,
  input  pd_t       pd,
  output rrat_map_t map
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) map[i] <= pd_t'(i);
    end else if (we && rd != '0) begin
      map[rd] <= pd;
    end
  end

endmodule

// File: rtl/rob_commit_unit.sv
// Retires the ROB head: RRAT update, freelist return, store push, predictor training and
// mispredict flush. Optional RVFI trace outputs when COMMIT_RVFI_EN is defined.
//
// state    | meaning
// CS_RUN   | normal commit, at most one entry per cycle
// CS_FLUSH | one cycle after a mispredict; nothing retires
// CS_HALT  | exception retired; frozen until reset
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  ROB_to_RRF_t                                rob_head_i,
  output RRF_to_ROB_t                                rob_deq_o,
  output logic                                       free_valid_o,
  output logic [PHYS_REG_IDX:0]                      free_pd_o,
  output logic                                       pcsb_valid_o,
  output pcsb_entry_t                                pcsb_entry_o,
  input  logic                                       pcsb_ready_i,
  output logic                                       bp_upd_valid_o,
  output logic [7:0]                                 bp_upd_idx_o,
  output logic                                       bp_upd_taken_o,
  output logic                                       flush_o,
  output logic [31:0]                                flush_pc_o,
  output logic [NUM_ARCH_REG*(PHYS_REG_IDX+1)-1:0]   rrat_map_o,
`ifdef COMMIT_RVFI_EN
  output logic                                       rvfi_valid,
  output logic [63:0]                                rvfi_order,
  output logic [31:0]                                rvfi_inst,
  output logic [31:0]                                rvfi_pc_rdata,
  output logic [31:0]                                rvfi_pc_wdata,
  output logic [4:0]                                 rvfi_rd_addr,
  output logic [31:0]                                rvfi_rd_wdata,
  output logic [4:0]                                 rvfi_rs1_addr,
  output logic [31:0]                                rvfi_rs1_rdata,
  output logic [4:0]                                 rvfi_rs2_addr,
  output logic [31:0]                                rvfi_rs2_rdata,
  output logic [31:0]                                rvfi_mem_addr,
  output logic [3:0]                                 rvfi_mem_wmask,
  output logic [31:0]                                rvfi_mem_wdata,
`endif
  output logic                                       halt_o
);

  commit_state_t state;
  rob_entry_t    entry;
  bp_update_t    bp_q;
  rrat_map_t     rrat_map;
  logic          is_store, commit, mispredict, rrat_we;
  logic [31:0]   redirect_pc;

  assign entry       = rob_head_i.rob_entry;
  assign is_store    = entry.opcode == op_b_store;
  assign commit      = state == CS_RUN && !rob_head_i.is_rob_empty && entry.ready &&
                       (!is_store || pcsb_ready_i || entry.exc);
  assign mispredict  = (entry.br_taken != entry.pred_taken) ||
                       (entry.br_taken && entry.br_target != entry.pred_target);
  assign redirect_pc = entry.br_taken ? entry.br_target : entry.pc + 32'd4;
  assign rrat_we     = commit && !entry.exc && entry.dest_we && entry.rd != '0;

  assign rob_deq_o      = '{dequeue: commit};
  assign bp_upd_valid_o = bp_q.valid;
  assign bp_upd_idx_o   = bp_q.idx;
  assign bp_upd_taken_o = bp_q.taken;
  assign rrat_map_o     = rrat_map;

  rob_commit_unit_rrat u_rrat (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rrat_we),
    .rd    (entry.rd),
    .pd    (entry.pd),
    .map   (rrat_map)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= CS_RUN;
      free_valid_o <= 1'b0;
      free_pd_o    <= '0;
      pcsb_valid_o <= 1'b0;
      pcsb_entry_o <= '0;
      bp_q         <= '0;
      flush_o      <= 1'b0;
      flush_pc_o   <= '0;
      halt_o       <= 1'b0;
    end else begin
      free_valid_o       <= 1'b0;
      pcsb_valid_o       <= 1'b0;
      pcsb_entry_o.valid <= 1'b0;
      bp_q.valid         <= 1'b0;
      flush_o            <= 1'b0;
      case (state)
        CS_RUN: begin
          if (commit && entry.exc) begin
            halt_o <= 1'b1;
            state  <= CS_HALT;
          end else if (commit) begin
            if (rrat_we) begin
              free_valid_o <= 1'b1;
              free_pd_o    <= entry.pd_old;
            end
            if (is_store) begin
              pcsb_valid_o <= 1'b1;
              pcsb_entry_o <= '{valid: 1'b1, addr: entry.mem_addr,
                               wmask: entry.mem_wmask, wdata: entry.mem_wdata};
            end
            if (entry.is_branch) begin
              bp_q <= '{valid: 1'b1, idx: entry.bht_idx, taken: entry.br_taken};
              if (mispredict) begin
                flush_o    <= 1'b1;
                flush_pc_o <= redirect_pc;
                state      <= CS_FLUSH;
              end
            end
          end
        end
        CS_FLUSH: state <= CS_RUN;
        CS_HALT:  state <= CS_HALT;
        default:  state <= CS_RUN;
      endcase
    end
  end

`ifdef COMMIT_RVFI_EN
  logic rd_visible;
  assign rd_visible = entry.dest_we && entry.rd != '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= '0;
      rvfi_inst      <= '0;
      rvfi_pc_rdata  <= '0;
      rvfi_pc_wdata  <= '0;
      rvfi_rd_addr   <= '0;
      rvfi_rd_wdata  <= '0;
      rvfi_rs1_addr  <= '0;
      rvfi_rs1_rdata <= '0;
      rvfi_rs2_addr  <= '0;
      rvfi_rs2_rdata <= '0;
      rvfi_mem_addr  <= '0;
      rvfi_mem_wmask <= '0;
      rvfi_mem_wdata <= '0;
    end else begin
      rvfi_valid <= commit;
      if (commit) begin
        rvfi_order     <= rvfi_order + 64'd1;
        rvfi_inst      <= entry.inst;
        rvfi_pc_rdata  <= entry.pc;
        rvfi_pc_wdata  <= (entry.is_branch && mispredict) ? redirect_pc : entry.pc + 32'd4;
        rvfi_rd_addr   <= rd_visible ? entry.rd : 5'd0;
        rvfi_rd_wdata  <= rd_visible ? entry.rd_wdata : 32'd0;
        rvfi_rs1_addr  <= entry.rs1_addr;
        rvfi_rs1_rdata <= entry.rs1_rdata;
        rvfi_rs2_addr  <= entry.rs2_addr;
        rvfi_rs2_rdata <= entry.rs2_rdata;
        rvfi_mem_addr  <= entry.mem_addr;
        rvfi_mem_wmask <= entry.mem_wmask;
        rvfi_mem_wdata <= entry.mem_wdata;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: reset, ALU/store/branch/exception retirement, flush and halt.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic                                     clk = 1'b0;
  logic                                     rst_n;
  ROB_to_RRF_t                              rob_head_i;
  RRF_to_ROB_t                              rob_deq_o;
  logic                                     free_valid_o;
  logic [PHYS_REG_IDX:0]                    free_pd_o;
  logic                                     pcsb_valid_o;
  pcsb_entry_t                              pcsb_entry_o;
  logic                                     pcsb_ready_i;
  logic                                     bp_upd_valid_o;
  logic [7:0]                               bp_upd_idx_o;
  logic                                     bp_upd_taken_o;
  logic                                     flush_o;
  logic [31:0]                              flush_pc_o;
  logic [NUM_ARCH_REG*(PHYS_REG_IDX+1)-1:0] rrat_map_o;
  logic                                     halt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rob_head_i     (rob_head_i),
    .rob_deq_o      (rob_deq_o),
    .free_valid_o   (free_valid_o),
    .free_pd_o      (free_pd_o),
    .pcsb_valid_o   (pcsb_valid_o),
    .pcsb_entry_o   (pcsb_entry_o),
    .pcsb_ready_i   (pcsb_ready_i),
    .bp_upd_valid_o (bp_upd_valid_o),
    .bp_upd_idx_o   (bp_upd_idx_o),
    .bp_upd_taken_o (bp_upd_taken_o),
    .flush_o        (flush_o),
    .flush_pc_o     (flush_pc_o),
    .rrat_map_o     (rrat_map_o),
    .halt_o         (halt_o)
  );

  function automatic pd_t rrat(input int i);
    return rrat_map_o[i*(PHYS_REG_IDX+1) +: (PHYS_REG_IDX+1)];
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_empty();
    rob_head_i = '0;
    rob_head_i.is_rob_empty = 1'b1;
  endtask

  task automatic set_alu(input rd_t rd, input pd_t pd, input pd_t pd_old);
    rob_head_i = '0;
    rob_head_i.rob_entry.ready   = 1'b1;
    rob_head_i.rob_entry.opcode  = op_b_reg;
    rob_head_i.rob_entry.rd      = rd;
    rob_head_i.rob_entry.pd      = pd;
    rob_head_i.rob_entry.pd_old  = pd_old;
    rob_head_i.rob_entry.dest_we = 1'b1;
  endtask

  task automatic set_branch(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                            input logic bt, input logic [31:0] btgt, input logic [7:0] idx);
    rob_head_i = '0;
    rob_head_i.rob_entry.ready       = 1'b1;
    rob_head_i.rob_entry.opcode      = op_b_br;
    rob_head_i.rob_entry.is_branch   = 1'b1;
    rob_head_i.rob_entry.pc          = pc;
    rob_head_i.rob_entry.pred_taken  = pt;
    rob_head_i.rob_entry.pred_target = ptgt;
    rob_head_i.rob_entry.br_taken    = bt;
    rob_head_i.rob_entry.br_target   = btgt;
    rob_head_i.rob_entry.bht_idx     = idx;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_empty();
    pcsb_ready_i = 1'b1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rob_deq_o.dequeue !== 1'b0) begin errors++; $display("FAIL reset_deq: got %b expected 0", rob_deq_o.dequeue); end
      checks++;
      if ({free_valid_o, pcsb_valid_o, bp_upd_valid_o, flush_o, halt_o} !== 5'b0) begin
        errors++;
        $display("FAIL reset_pulses: got %b expected 00000",
                 {free_valid_o, pcsb_valid_o, bp_upd_valid_o, flush_o, halt_o});
      end
      step();
    end
    for (int i = 0; i < NUM_ARCH_REG; i++) begin
      checks++;
      if (rrat(i) !== pd_t'(i)) begin errors++; $display("FAIL reset_rrat[%0d]: got %0d expected %0d", i, rrat(i), i); end
    end
  endtask

  task automatic test_alu_commit();
    set_alu(5'd5, 6'd40, 6'd5);
    #1;
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL alu_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
    checks++;
    if (free_valid_o !== 1'b1) begin errors++; $display("FAIL alu_free_valid: got %b expected 1", free_valid_o); end
    checks++;
    if (free_pd_o !== 6'd5) begin errors++; $display("FAIL alu_free_pd: got %0d expected 5", free_pd_o); end
    checks++;
    if (rrat(5) !== 6'd40) begin errors++; $display("FAIL alu_rrat5: got %0d expected 40", rrat(5)); end
    step();
    checks++;
    if (free_valid_o !== 1'b0) begin errors++; $display("FAIL alu_free_pulse: got %b expected 0", free_valid_o); end
  endtask

  task automatic test_store_stall();
    rob_head_i = '0;
    rob_head_i.rob_entry.ready     = 1'b1;
    rob_head_i.rob_entry.opcode    = op_b_store;
    rob_head_i.rob_entry.mem_addr  = 32'h1000_0004;
    rob_head_i.rob_entry.mem_wmask = 4'b1111;
    rob_head_i.rob_entry.mem_wdata = 32'hDEAD_BEEF;
    pcsb_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (rob_deq_o.dequeue !== 1'b0) begin errors++; $display("FAIL st_stall_deq: got %b expected 0", rob_deq_o.dequeue); end
      step();
      checks++;
      if (pcsb_valid_o !== 1'b0) begin errors++; $display("FAIL st_stall_push: got %b expected 0", pcsb_valid_o); end
    end
    pcsb_ready_i = 1'b1;
    #1;
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL st_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
    checks++;
    if (pcsb_valid_o !== 1'b1) begin errors++; $display("FAIL st_push: got %b expected 1", pcsb_valid_o); end
    checks++;
    if (pcsb_entry_o !== {1'b1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL st_entry: got %h expected %h", pcsb_entry_o, {1'b1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF});
    end
    checks++;
    if (free_valid_o !== 1'b0) begin errors++; $display("FAIL st_no_free: got %b expected 0", free_valid_o); end
    step();
    checks++;
    if (pcsb_valid_o !== 1'b0) begin errors++; $display("FAIL st_push_pulse: got %b expected 0", pcsb_valid_o); end
  endtask

  task automatic test_mispredict_taken();
    set_branch(32'h60, 1'b0, 32'h0, 1'b1, 32'h80, 8'h12);
    #1;
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL mp_t_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_alu(5'd6, 6'd41, 6'd6);
    #1;
    checks++;
    if (flush_o !== 1'b1) begin errors++; $display("FAIL mp_t_flush: got %b expected 1", flush_o); end
    checks++;
    if (flush_pc_o !== 32'h80) begin errors++; $display("FAIL mp_t_flush_pc: got %h expected 00000080", flush_pc_o); end
    checks++;
    if ({bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o} !== {1'b1, 8'h12, 1'b1}) begin
      errors++; $display("FAIL mp_t_bp: got %b_%h_%b expected 1_12_1", bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o);
    end
    checks++;
    if (rob_deq_o.dequeue !== 1'b0) begin errors++; $display("FAIL mp_t_flush_deq: got %b expected 0", rob_deq_o.dequeue); end
    step();
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL mp_t_flush_pulse: got %b expected 0", flush_o); end
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL mp_t_resume_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
    checks++;
    if (rrat(6) !== 6'd41) begin errors++; $display("FAIL mp_t_resume_rrat6: got %0d expected 41", rrat(6)); end
    step();
  endtask

  task automatic test_mispredict_not_taken();
    set_branch(32'h60, 1'b1, 32'h200, 1'b0, 32'h200, 8'h07);
    rob_head_i.rob_entry.rd      = 5'd7;
    rob_head_i.rob_entry.pd      = 6'd42;
    rob_head_i.rob_entry.pd_old  = 6'd7;
    rob_head_i.rob_entry.dest_we = 1'b1;
    step();
    set_empty();
    checks++;
    if ({flush_o, flush_pc_o} !== {1'b1, 32'h64}) begin errors++; $display("FAIL mp_nt_flush: got %b/%h expected 1/00000064", flush_o, flush_pc_o); end
    checks++;
    if ({bp_upd_valid_o, bp_upd_taken_o} !== 2'b10) begin errors++; $display("FAIL mp_nt_bp: got %b expected 10", {bp_upd_valid_o, bp_upd_taken_o}); end
    checks++;
    if (rrat(7) !== 6'd42) begin errors++; $display("FAIL mp_nt_rrat7: got %0d expected 42", rrat(7)); end
    checks++;
    if ({free_valid_o, free_pd_o} !== {1'b1, 6'd7}) begin errors++; $display("FAIL mp_nt_free: got %b/%0d expected 1/7", free_valid_o, free_pd_o); end
    step();
    // Taken with correct direction but wrong target still redirects.
    set_branch(32'h300, 1'b1, 32'h100, 1'b1, 32'h104, 8'h33);
    step();
    set_empty();
    checks++;
    if ({flush_o, flush_pc_o} !== {1'b1, 32'h104}) begin errors++; $display("FAIL mp_tgt_flush: got %b/%h expected 1/00000104", flush_o, flush_pc_o); end
    step();
  endtask

  task automatic test_correct_predict();
    set_branch(32'h400, 1'b1, 32'h100, 1'b1, 32'h100, 8'hA5);
    step();
    set_branch(32'h404, 1'b0, 32'h0, 1'b0, 32'h900, 8'h5A);
    #1;
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL ok_t_flush: got %b expected 0", flush_o); end
    checks++;
    if ({bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o} !== {1'b1, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL ok_t_bp: got %b_%h_%b expected 1_a5_1", bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o);
    end
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL ok_b2b_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
    checks++;
    if ({flush_o, bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o} !== {1'b0, 1'b1, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL ok_nt_bp: got %b_%b_%h_%b expected 0_1_5a_0", flush_o, bp_upd_valid_o, bp_upd_idx_o, bp_upd_taken_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    set_alu(5'd9, 6'd20, 6'd9);
    step();
    set_alu(5'd9, 6'd21, 6'd20);
    #1;
    checks++;
    if ({free_valid_o, free_pd_o} !== {1'b1, 6'd9}) begin errors++; $display("FAIL b2b_free0: got %b/%0d expected 1/9", free_valid_o, free_pd_o); end
    step();
    set_alu(5'd0, 6'd22, 6'd33);
    #1;
    checks++;
    if ({free_valid_o, free_pd_o} !== {1'b1, 6'd20}) begin errors++; $display("FAIL b2b_free1: got %b/%0d expected 1/20", free_valid_o, free_pd_o); end
    checks++;
    if (rrat(9) !== 6'd21) begin errors++; $display("FAIL b2b_rrat9: got %0d expected 21", rrat(9)); end
    step();
    set_empty();
    checks++;
    if ({free_valid_o, rrat(0)} !== {1'b0, 6'd0}) begin errors++; $display("FAIL b2b_x0: got %b/%0d expected 0/0", free_valid_o, rrat(0)); end
  endtask

  task automatic test_reset_mid_flush();
    set_branch(32'h60, 1'b0, 32'h0, 1'b1, 32'h80, 8'h01);
    step();
    set_empty();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b expected 0", flush_o); end
    set_alu(5'd4, 6'd44, 6'd4);
    #1;
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL rst_flush_run: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
  endtask

  task automatic test_exception();
    set_alu(5'd3, 6'd50, 6'd3);
    rob_head_i.rob_entry.exc = 1'b1;
    #1;
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL exc_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_alu(5'd8, 6'd55, 6'd8);
    #1;
    checks++;
    if (halt_o !== 1'b1) begin errors++; $display("FAIL exc_halt: got %b expected 1", halt_o); end
    checks++;
    if ({free_valid_o, rrat(3)} !== {1'b0, 6'd3}) begin errors++; $display("FAIL exc_no_side: got %b/%0d expected 0/3", free_valid_o, rrat(3)); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({rob_deq_o.dequeue, halt_o} !== 2'b01) begin errors++; $display("FAIL exc_frozen: got %b expected 01", {rob_deq_o.dequeue, halt_o}); end
      step();
    end
    do_reset();
    checks++;
    if ({halt_o, rrat(5), rrat(8)} !== {1'b0, 6'd5, 6'd8}) begin
      errors++; $display("FAIL exc_reset: got %b/%0d/%0d expected 0/5/8", halt_o, rrat(5), rrat(8));
    end
    checks++;
    if (rob_deq_o.dequeue !== 1'b1) begin errors++; $display("FAIL exc_reset_deq: got %b expected 1", rob_deq_o.dequeue); end
    step();
    set_empty();
  endtask

  initial begin
    rst_n = 1'b0;
    pcsb_ready_i = 1'b1;
    set_empty();
    test_reset();
    test_alu_commit();
    test_store_stall();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_correct_predict();
    test_back_to_back();
    test_reset_mid_flush();
    test_exception();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Consumer end of the ROB head interface: reads the ROB head (ROB_to_RRF_t), decides retirement, and returns dequeue (RRF_to_ROB_t).
- On retirement: updates the retirement RAT (RRAT), returns the old physical register to the freelist, and pushes committed stores to the post-commit store buffer.
- Trains the branch predictor and raises a one-cycle pipeline flush with the corrected PC on a mispredicted branch.

Parameters:
- NUM_ARCH_REG, 32, architectural registers; value from rv32i_types.
- NUM_PHYS_REG, 64, physical registers; value from rv32i_types.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rob_head_i  in  ROB_to_RRF_t  ROB head entry plus is_rob_empty
- rob_deq_o  out  RRF_to_ROB_t  dequeue (advance ROB head) this cycle
- free_valid_o  out  1  return a physical register to the freelist
- free_pd_o  out  PHYS_REG_IDX+1  physical register returned
- pcsb_valid_o  out  1  push a committed store
- pcsb_entry_o  out  pcsb_entry_t  addr/wmask/wdata of the store
- pcsb_ready_i  in  1  store buffer can accept a push
- bp_upd_valid_o  out  1  predictor update
- bp_upd_idx_o  out  8  bht_idx of the retired branch
- bp_upd_taken_o  out  1  resolved direction
- flush_o  out  1  mispredict flush
- flush_pc_o  out  32  corrected fetch PC
- rrat_map_o  out  NUM_ARCH_REG*(PHYS_REG_IDX+1)  full retirement map, used for RAT restore on flush
- halt_o  out  1  sticky; exception retired

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values:
  - All outputs 0, except rrat[i]=i for every i.
  - State RUN.
  - Reset in any state (including mid-FLUSH) returns to RUN the next edge, with flush_o=0.
- States:
  - RUN: normal commit.
  - FLUSH: exactly one cycle; no commit.
  - HALT: terminal until reset; no commit.
- commit = (state==RUN) & !is_rob_empty & rob_entry.ready & (!is_store | pcsb_ready_i | exc).
  - is_store means opcode==op_b_store.
- rob_deq_o.dequeue = commit. It is combinational, same cycle as the head is presented. At most one retirement per cycle.
- Registered outputs: free, pcsb, bp_upd, flush and halt are registered and valid the cycle after commit. Each valid is a one-cycle pulse.
- RRAT:
  - On commit with dest_we & rd!=0 & !exc: rrat[rd] <= pd.
  - free_pd_o <= pd_old, free_valid_o <= 1.
  - rd==0 never writes the RRAT and never frees.
- Stores: on a commit of a non-exc store, pcsb_entry_o <= {1, mem_addr, mem_wmask, mem_wdata}. If pcsb_ready_i=0 the store stalls: no dequeue, no side effects.
- Branches:
  - On commit with is_branch: bp_upd_valid_o=1, idx=bht_idx, taken=br_taken.
  - Mispredict = br_taken!=pred_taken | (br_taken & br_target!=pred_target).
  - On mispredict: next cycle flush_o=1, flush_pc_o = br_taken ? br_target : pc+4 (32-bit wrap), state->FLUSH. After one FLUSH cycle, ->RUN.
  - The mispredicted branch's own RRAT update and free still take effect. rrat_map_o in the flush cycle reflects them.
- Exceptions: commit with exc -> dequeue, no RRAT/free/pcsb/bp side effects; next cycle halt_o=1, state->HALT.
- Empty ROB, or head not ready: no dequeue, all pulses 0.
- Back-to-back commits: one per cycle in RUN. Consecutive writes to the same rd are applied in commit order.

Optional Feature:
- Macro: COMMIT_RVFI_EN.
- Defined:
  - Adds outputs rvfi_valid, rvfi_order (64), rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_addr, rvfi_rd_wdata, rvfi_rs1_addr/rdata, rvfi_rs2_addr/rdata, rvfi_mem_addr/wmask/wdata.
  - All are registered from the committed entry with the same one-cycle latency.
  - pc_wdata is flush_pc on mispredict, else pc+4. rd_addr/wdata are forced to 0 when rd==0 or !dest_we.
- Undefined: no rvfi ports, no rvfi logic.

Decomposition:
- Add to rv32i_types:
  - commit_state_t enum {CS_RUN, CS_FLUSH, CS_HALT}
  - rrat_map_t (packed array [NUM_ARCH_REG] of pd_t)
  - bp_update_t {valid, idx[7:0], taken}
- Sub-module rrat_regfile:
  - Identity reset, one synchronous write port (we, rd, pd), flattened map read-out.
  - Writes with rd==0 are ignored internally.

Test Plan:
- Reset, then an empty ROB for 5 cycles -> dequeue=0 throughout; rrat_map_o entries {0,1,...,31}; all pulses 0.
- Ready head {rd=5, pd=40, pd_old=5, dest_we=1} -> dequeue same cycle; next cycle free_valid=1, free_pd=5, rrat[5]=40.
- Ready store {mem_addr=0x1000_0004, wmask=4'b1111, wdata=0xDEADBEEF} with pcsb_ready_i=0 for 3 cycles then 1 -> no dequeue for 3 cycles; dequeue on cycle 4; pcsb push with those exact values the cycle after.
- Branch {pc=0x60, pred_taken=0, br_taken=1, br_target=0x80, bht_idx=0x12} -> bp_upd {0x12, taken=1}; flush_o=1 for exactly one cycle with flush_pc=0x80; head held ready during FLUSH is not dequeued; commit resumes the next cycle.
- Branch {pc=0x60, pred_taken=1, br_taken=0} -> flush_pc=0x64. Branch with matching prediction -> no flush.
- Head {exc=1, rd=3, dest_we=1} -> dequeue; rrat[3] unchanged; halt_o=1 sticky; later ready heads not dequeued until rst_n=0.
